// File: rtl/dram_dump_tx_pkg.sv
// Shared definitions for the DRAM dump transmitter: FSM encodings,
// UART line levels and the default baud divider.
package dram_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    WAIT    = 3'd2,
    START_B = 3'd3,
    DATA    = 3'd4,
    STOP_B  = 3'd5,
    DONE    = 3'd6
  } dump_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

  // 50 MHz system clock, 115200 baud
  localparam int DEF_CLKS_PER_BIT = 434;

  // Width of a counter that must hold 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_dump_tx_if.sv
// Host/DRAM-facing signals of the dump transmitter. The slave modport is
// the dump block itself; the master modport is the host, DRAM and UART
// line side.
interface dram_dump_tx_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_q;
  logic              own;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, len, dram_q,
    input  dram_addr, own, tx, busy, done
  );

  modport slave (
    input  start, base_addr, len, dram_q,
    output dram_addr, own, tx, busy, done
  );

endinterface

// File: rtl/dram_dump_tx_uart_tx_core.sv
// 8N1-style UART transmitter: one start bit, DATA_W data bits LSB first,
// one stop bit. A load pulse while idle captures din and starts a frame.
module uart_tx_core
  import dram_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  dump_state_e       phase_q, phase_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              tick;

  assign tick    = (baud_q == BAUD_LAST);
  assign tx      = tx_q;
  assign tx_busy = (phase_q != IDLE);
  // Asserted during the final clock of the stop bit
  assign tx_done = (phase_q == STOP_B) && tick;

  // Frame sequencing: the next line level is registered so tx never glitches
  always_comb begin
    phase_d = phase_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (phase_q)
      IDLE: begin
        if (load) begin
          shreg_d = din;
          baud_d  = '0;
          tx_d    = UART_START_LVL;
          phase_d = START_B;
        end
      end
      START_B: begin
        if (tick) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          phase_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = UART_STOP_LVL;
            phase_d = STOP_B;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP_B: begin
        if (tick) begin
          baud_d  = '0;
          tx_d    = UART_IDLE_LVL;
          phase_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = UART_IDLE_LVL;
        phase_d = IDLE;
      end
    endcase
  end

  // Transmitter state register; reset drives the line idle immediately
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      phase_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/dram_dump_tx.sv
// Dumps a block of DRAM over a UART line. Holds the DRAM address port
// (own=1) from acceptance of start until the DONE cycle so the processor
// cannot write mid-dump. Address/length sequencing lives here; framing
// lives in uart_tx_core.
module dram_dump_tx
  import dram_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LAT     = 2
) (
  input logic           CLK,
  input logic           rst,
  dram_dump_tx_if.slave bus
);

  localparam int REM_W = ADDR_W + 1;
  localparam int LAT_W = cnt_width(READ_LAT);
  localparam logic [LAT_W-1:0] WAIT_LAST  = LAT_W'(READ_LAT - 1);
  localparam logic [REM_W-1:0] FULL_BLOCK = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [REM_W-1:0] ONE_LEFT   = REM_W'(1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [LAT_W-1:0]  wait_q, wait_d;
  logic              busy_q, own_q, done_q;
  logic              active_d;
  logic              load;
  logic              tx_w, tx_busy, tx_done;

  // Read data is valid on the last WAIT cycle; hand it to the serialiser
  assign load = (state_q == WAIT) && (wait_q == WAIT_LAST) && !tx_busy;

  assign bus.dram_addr = addr_q;
  assign bus.own       = own_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tx        = tx_w;

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_tx (
    .CLK     (CLK),
    .rst     (rst),
    .load    (load),
    .din     (bus.dram_q),
    .tx      (tx_w),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  // Dump sequencing; START_B stands for the whole serial frame here, the
  // core walks through start/data/stop on its own
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    active_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          rem_d   = (bus.len == '0) ? FULL_BLOCK : {1'b0, bus.len};
          state_d = ADDR;
        end
      end
      ADDR: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (load) begin
          state_d = START_B;
        end else if (wait_q != WAIT_LAST) begin
          wait_d = wait_q + 1'b1;
        end
      end
      START_B: begin
        if (tx_done) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == ONE_LEFT) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ADDR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    active_d = (state_d == ADDR) || (state_d == WAIT) || (state_d == START_B);
  end

  // Control registers; busy/own/done are registered from the next state
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      own_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wait_q  <= wait_d;
      busy_q  <= active_d;
      own_q   <= active_d;
      done_q  <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_dram_dump_tx.sv
// Bench for dram_dump_tx: DRAM model with two-cycle read latency, a UART
// line decoder, and directed plus randomized dumps checked against the
// expected byte stream and done timing.
module tb_dram_dump_tx;

  localparam int CPB = 4;
  localparam int LAT = 2;
  localparam int AW  = 8;
  localparam int DW  = 8;
  // Cycles per byte: ADDR, READ_LAT wait cycles, then the serial frame
  localparam int PER_BYTE = 1 + LAT + (DW + 2) * CPB;

  logic CLK = 1'b0;
  logic rst;

  dram_dump_tx_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dram_dump_tx #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LAT     (LAT)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dumps_expected = 0;
  int frame_err = 0;

  logic [7:0] mem [256];
  logic [7:0] rd_p1;
  logic [7:0] rx_q [$];

  // DRAM: data for the address presented in cycle t appears in cycle t+2
  always @(posedge CLK) begin
    rd_p1      <= mem[bus.dram_addr];
    bus.dram_q <= rd_p1;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!rst && bus.done === 1'b1) done_cnt++;
  end

  // UART receiver: each bit must hold one level for CPB cycles
  logic       rx_active = 1'b0;
  int         rx_t;
  int         rx_b;
  logic       rx_cur;
  logic [7:0] rx_byte;
  always @(negedge CLK) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (bus.tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
        rx_cur    = 1'b0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == 0) rx_cur = bus.tx;
      else if (bus.tx !== rx_cur) frame_err++;
      if (rx_t % CPB == CPB - 1) begin
        rx_b = rx_t / CPB;
        if (rx_b == 0) begin
          if (rx_cur !== 1'b0) frame_err++;
        end else if (rx_b <= DW) begin
          rx_byte[rx_b-1] = rx_cur;
        end else begin
          if (rx_cur !== 1'b1) frame_err++;
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic wait_done(input int budget, output int at, output int nbytes,
                           output logic own_at, output logic busy_at);
    at = -1; nbytes = -1; own_at = 1'bx; busy_at = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (bus.done === 1'b1) begin
        at = cyc; nbytes = rx_q.size(); own_at = bus.own; busy_at = bus.busy;
        break;
      end
    end
  endtask

  task automatic begin_dump(input logic [7:0] base, input logic [7:0] ln, output int acc);
    rx_q.delete();
    frame_err = 0;
    @(negedge CLK);
    bus.start = 1'b1; bus.base_addr = base; bus.len = ln;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    acc = cyc;
    chk("addr_after_accept", 32'(bus.dram_addr), 32'(base));
    chk("own_after_accept", 32'(bus.own), 32'd1);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic finish_dump(input string tag, input logic [7:0] base, input logic [7:0] ln,
                             input int acc);
    int n, at, nb;
    logic oa, ba;
    logic [7:0] a;
    n = (ln == 8'd0) ? 256 : int'(ln);
    wait_done(n * PER_BYTE + 20, at, nb, oa, ba);
    chk({tag, "_done_cycle"}, 32'(at), 32'(acc + n * PER_BYTE));
    chk({tag, "_bytes_at_done"}, 32'(nb), 32'(n));
    chk({tag, "_own_at_done"}, 32'(oa), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(ba), 32'd0);
    for (int k = 0; k < n && k < rx_q.size(); k++) begin
      a = base + 8'(k);
      chk({tag, "_byte"}, 32'(rx_q[k]), 32'(mem[a]));
    end
    chk({tag, "_framing"}, 32'(frame_err), 32'd0);
    dumps_expected++;
  endtask

  int acc;
  int n_before;
  logic [7:0] rb, rl;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_own", 32'(bus.own), 32'd0);
    chk("rst_dram_addr", 32'(bus.dram_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_tx", 32'(bus.tx), 32'd1);

    // Single byte from 0x10 -> 0xB5
    begin_dump(8'h10, 8'd1, acc);
    finish_dump("single", 8'h10, 8'd1, acc);
    if (rx_q.size() > 0) chk("single_literal", 32'(rx_q[0]), 32'hB5);
    @(negedge CLK);
    chk("single_tx_after", 32'(bus.tx), 32'd1);

    // Three bytes wrapping 0xFE,0xFF,0x00; start during byte 2 and during DONE
    begin_dump(8'hFE, 8'd3, acc);
    wait_cyc(acc + PER_BYTE + 17);
    bus.start = 1'b1; bus.base_addr = 8'h80; bus.len = 8'd1;
    @(negedge CLK);
    bus.start = 1'b0;
    chk("busy_start_addr", 32'(bus.dram_addr), 32'hFF);
    chk("busy_start_busy", 32'(bus.busy), 32'd1);
    finish_dump("wrap", 8'hFE, 8'd3, acc);
    if (rx_q.size() == 3) begin
      chk("wrap_b0", 32'(rx_q[0]), 32'h5B);
      chk("wrap_b1", 32'(rx_q[1]), 32'h5A);
      chk("wrap_b2", 32'(rx_q[2]), 32'hA5);
    end
    bus.start = 1'b1; bus.base_addr = 8'h80; bus.len = 8'd1;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    chk("done_start_busy", 32'(bus.busy), 32'd0);
    chk("done_start_own", 32'(bus.own), 32'd0);
    n_before = rx_q.size();
    repeat (8) @(negedge CLK);
    chk("done_start_idle", 32'(bus.busy), 32'd0);
    chk("done_start_no_frame", 32'(rx_q.size()), 32'(n_before));

    // Reset during data bit 3 of a two-byte dump from 0x20
    begin_dump(8'h20, 8'd2, acc);
    wait_cyc(acc + 3 + CPB * 4 + 1);
    chk("midframe_bit3", 32'(bus.tx), 32'(mem[8'h20][3]));
    rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(bus.tx), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_own", 32'(bus.own), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_addr", 32'(bus.dram_addr), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    chk("postrst_tx", 32'(bus.tx), 32'd1);
    begin_dump(8'h30, 8'd1, acc);
    finish_dump("postrst", 8'h30, 8'd1, acc);

    // len=0 means the full 256-byte space
    begin_dump(8'h00, 8'd0, acc);
    finish_dump("full", 8'h00, 8'd0, acc);
    if (rx_q.size() == 256) chk("full_last_byte", 32'(rx_q[255]), 32'(mem[8'hFF]));

    // Randomized content, base and length
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      rb = 8'($urandom);
      rl = 8'($urandom_range(1, 5));
      begin_dump(rb, rl, acc);
      finish_dump("random", rb, rl, acc);
    end

    repeat (5) @(negedge CLK);
    chk("done_pulse_count", 32'(done_cnt), 32'(dumps_expected));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
